ntsc_packer: RTL

Capture-side stage that feeds the memory interface's NTSC client port. Accepts one truncated pixel per cycle from the NTSC decoder and packs PACK pixels into one memory word. Buffers completed words in a small FIFO and presents them on the `ntsc_flag`/`ntsc_pixel`/`done_ntsc` handshake, absorbing arbitration stalls in the memory interface.

---
 rtl/ntsc_packer.sv | 119 +++++++++++
 1 files changed

// File: rtl/ntsc_packer.sv
// Packs PACK truncated NTSC pixels into one memory word and queues finished words
// in a small FIFO drained through the ntsc_flag / done_ntsc handshake.
module ntsc_packer #(
  parameter int PIX_W     = 12,
  parameter int PACK      = 3,
  parameter int DEPTH     = 4,
  parameter int LOG_DEPTH = 2,
  localparam int MEM_W    = PACK * PIX_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               pixel_valid,
  input  logic [PIX_W-1:0]   pixel,
  output logic               ntsc_flag,
  output logic [MEM_W-1:0]   ntsc_pixel,
  input  logic               done_ntsc,
  output logic               overflow,
  output logic [15:0]        word_count
);

  localparam int SLOT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(PACK - 1);
  localparam logic [LOG_DEPTH:0] FULL_CNT  = (LOG_DEPTH + 1)'(DEPTH);

  // Packer state
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_eff;
  logic [SLOT_W-1:0] slot_next;
  logic [MEM_W-1:0]  shreg;
  logic [MEM_W-1:0]  word_next;
  logic              frame_restart;
  logic              word_done;

  // FIFO state
  logic [MEM_W-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 push_ok;
  logic                 pop;

  assign frame_restart = pixel_valid && frame_start;

  // A restarting frame discards the partial word and lands its pixel in slot 0.
  always_comb begin
    slot_eff  = frame_restart ? '0 : slot;
    word_next = frame_restart ? '0 : shreg;
    for (int i = 0; i < PACK; i++) begin
      if (slot_eff == SLOT_W'(i)) begin
        word_next[MEM_W-1-i*PIX_W -: PIX_W] = pixel;
      end
    end
    word_done = pixel_valid && (slot_eff == LAST_SLOT);
    slot_next = word_done ? '0 : slot_eff + SLOT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot  <= '0;
      shreg <= '0;
    end else if (pixel_valid) begin
      slot  <= slot_next;
      shreg <= word_done ? '0 : word_next;
    end
  end

  // Handshake: ntsc_flag high means ntsc_pixel holds a valid word; the consumer
  // takes it by raising done_ntsc, and the word is removed at that clock edge.
  // done_ntsc while ntsc_flag is low has no effect.
  assign ntsc_flag  = (count != '0);
  assign ntsc_pixel = ntsc_flag ? mem[rd_ptr] : '0;
  assign pop        = done_ntsc && ntsc_flag;
  // A simultaneous pop frees the slot, so a full FIFO still accepts that push.
  assign push_ok    = word_done && ((count < FULL_CNT) || pop);

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= word_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      end
      case ({push_ok, pop})
        2'b10:   count <= count + (LOG_DEPTH + 1)'(1);
        2'b01:   count <= count - (LOG_DEPTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (word_done && !push_ok) begin
        overflow <= 1'b1;
      end
      if (frame_restart) begin
        word_count <= '0;
      end else if (pop && (word_count != 16'hFFFF)) begin
        word_count <= word_count + 16'd1;
      end
    end
  end

endmodule
